// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: header-tagged byte FIFO
// that tracks the header-declared packet length during read-out.
module router_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sft_rst,
   input  logic              write_en,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] data_in,
   input  logic              read_en,
   output logic [DATA_W-1:0] data_out,
   output logic              full,
   output logic              empty,
   output logic              rd_busy
);

   localparam int PTR_W = ADDR_W + 1;
   localparam int CNT_W = DATA_W - 1;

   logic [DATA_W:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [DATA_W:0]   rd_word;
   logic              wr_fire, rd_fire, clr;

   assign clr     = !rst || sft_rst;
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign wr_fire = write_en && !full;
   assign rd_fire = read_en && !empty;
   assign rd_word = mem_q[rd_ptr_q[ADDR_W-1:0]];

   assign data_out = data_out_q;
   assign rd_busy  = (cnt_q != '0);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      data_out_d = data_out_q;
      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_fire) begin
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         data_out_d = rd_word[DATA_W-1:0];
         // Header load counts payload bytes plus the trailing parity byte
         if (rd_word[DATA_W]) begin
            cnt_d = {1'b0, rd_word[DATA_W-1:2]} + CNT_W'(1);
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end else if (cnt_q == '0) begin
         data_out_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         data_out_q <= data_out_d;
      end
   end

   // Storage is never cleared; only the pointers define valid contents
   always_ff @(posedge clk) begin
      if (!clr && wr_fire) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
      end
   end

endmodule
